// File: rtl/btpipe_traffic_pkg.sv
// Shared encodings and the LFSR step for the BTPipe traffic engine.
// Pure definitions; no timing or flow-control behaviour of its own.
package btpipe_traffic_pkg;
   localparam logic [1:0] MODE_CNT  = 2'd0;
   localparam logic [1:0] MODE_LFSR = 2'd1;
   localparam logic [1:0] MODE_ALT  = 2'd2;

   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
   localparam logic [31:0] ALT_A     = 32'hAAAA_AAAA;
   localparam logic [31:0] ALT_5     = 32'h5555_5555;

   // Galois form, shifting right: the bit falling out selects the feedback.
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      lfsr_step = s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
   endfunction
endpackage

// File: rtl/btpipe_pattern_gen.sv
// Pattern source: registered word for the current index, one word per advance.
// Word updates the cycle after advance/load_mode; holds while advance is low.
module btpipe_pattern_gen
   import btpipe_traffic_pkg::*;
#(
   parameter int          DATA_W    = 128,
   parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
   input  logic              sys_clk,
   input  logic              rstn,
   input  logic              clear,
   input  logic              load_mode,
   input  logic [1:0]        mode,
   input  logic              advance,
   output logic [DATA_W-1:0] word
);
   localparam int LANES = DATA_W / 32;

   logic [1:0]        mode_q, mode_n;
   logic [31:0]       cnt_q, cnt_n;
   logic [31:0]       lfsr_q, lfsr_n;
   logic              par_q, par_n;
   logic [31:0]       lane_s, lane_w;
   logic [DATA_W-1:0] word_n, word_rst;

   // All three pattern states advance together, so a mode change at load
   // time still lands on the correct index for the new pattern.
   always_comb begin
      mode_n = load_mode ? mode : mode_q;
      cnt_n  = cnt_q;
      lfsr_n = lfsr_q;
      par_n  = par_q;
      lane_s = lfsr_q;
      for (int i = 0; i < LANES; i++) lane_s = lfsr_step(lane_s);
      if (advance) begin
         cnt_n  = cnt_q + 32'(LANES);
         lfsr_n = lane_s;
         par_n  = !par_q;
      end
      word_n   = '0;
      word_rst = '0;
      lane_w   = lfsr_n;
      for (int i = 0; i < LANES; i++) begin
         word_rst[i*32 +: 32] = 32'(i);
         case (mode_n)
            MODE_LFSR: begin
               word_n[i*32 +: 32] = lane_w;
               lane_w = lfsr_step(lane_w);
            end
            MODE_ALT: word_n[i*32 +: 32] = par_n ? ALT_5 : ALT_A;
            default:  word_n[i*32 +: 32] = cnt_n + 32'(i);
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!rstn || clear) begin
         mode_q <= MODE_CNT;
         cnt_q  <= '0;
         lfsr_q <= LFSR_SEED;
         par_q  <= 1'b0;
         word   <= word_rst;
      end else begin
         mode_q <= mode_n;
         cnt_q  <= cnt_n;
         lfsr_q <= lfsr_n;
         par_q  <= par_n;
         word   <= word_n;
      end
   end
endmodule

// File: rtl/btpipe_traffic_engine.sv
// BTPipe traffic source (F2P write side) and checker (P2F read side) with status counters.
// Write enable is combinational from gen_full (no overflow); reads stop once len are issued; status is registered.
module btpipe_traffic_engine
   import btpipe_traffic_pkg::*;
#(
   parameter int          DATA_W    = 128,
   parameter int          CNT_W     = 32,
   parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
   input  logic              sys_clk,
   input  logic              rstn,
   input  logic              cfg_clear,
   input  logic [1:0]        cfg_mode,
   input  logic [CNT_W-1:0]  cfg_len,
   input  logic              cfg_gen_en,
   input  logic              cfg_chk_en,
   output logic              gen_wr_en,
   output logic [DATA_W-1:0] gen_din,
   input  logic              gen_full,
   output logic              chk_rd_en,
   input  logic [DATA_W-1:0] chk_dout,
   input  logic              chk_valid,
   input  logic              chk_empty,
   output logic [CNT_W-1:0]  gen_count,
   output logic [CNT_W-1:0]  gen_cycles,
   output logic              gen_done,
   output logic [CNT_W-1:0]  chk_count,
   output logic [CNT_W-1:0]  chk_cycles,
   output logic [CNT_W-1:0]  err_count,
   output logic [CNT_W-1:0]  first_err_idx,
   output logic              chk_done
);
   localparam logic [1:0]       ST_IDLE = 2'd0;
   localparam logic [1:0]       ST_RUN  = 2'd1;
   localparam logic [1:0]       ST_DONE = 2'd2;
   localparam logic [CNT_W-1:0] ALL1    = '1;
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   logic [1:0]        gen_state, chk_state;
   logic [CNT_W-1:0]  gen_len_q, chk_len_q, chk_issued;
   logic [CNT_W-1:0]  gen_inc, chk_inc;
   logic              gen_load, chk_load, chk_hit, chk_bad, chk_last, last_issued, cyc_run;
   logic [DATA_W-1:0] exp_word;

   assign gen_load  = (gen_state == ST_IDLE) && cfg_gen_en;
   assign gen_wr_en = (gen_state == ST_RUN) && cfg_gen_en && !gen_full;
   assign gen_inc   = gen_count + ONE;
   assign gen_done  = (gen_state == ST_DONE);

   always_ff @(posedge sys_clk) begin
      if (!rstn || cfg_clear) begin
         gen_state  <= ST_IDLE;
         gen_len_q  <= '0;
         gen_count  <= '0;
         gen_cycles <= '0;
      end else begin
         case (gen_state)
            ST_IDLE: if (cfg_gen_en) begin
               gen_state <= ST_RUN;
               gen_len_q <= cfg_len;
            end
            ST_RUN: begin
               gen_cycles <= gen_cycles + ONE;
               if (gen_wr_en) begin
                  gen_count <= gen_inc;
                  if ((gen_len_q != '0) && (gen_inc == gen_len_q)) gen_state <= ST_DONE;
               end
            end
            ST_DONE: if (!cfg_gen_en) gen_state <= ST_IDLE;
            default: gen_state <= ST_IDLE;
         endcase
      end
   end

   btpipe_pattern_gen #(.DATA_W(DATA_W), .LFSR_SEED(LFSR_SEED)) u_gen_pat (
      .sys_clk(sys_clk), .rstn(rstn), .clear(cfg_clear), .load_mode(gen_load),
      .mode(cfg_mode), .advance(gen_wr_en), .word(gen_din)
   );

   // Data returned while RUN is checked even if cfg_chk_en has since dropped.
   assign chk_load    = (chk_state == ST_IDLE) && cfg_chk_en;
   assign last_issued = (chk_len_q != '0) && (chk_issued == chk_len_q);
   assign chk_rd_en   = (chk_state == ST_RUN) && cfg_chk_en && !chk_empty && !last_issued;
   assign chk_hit     = chk_valid && (chk_state == ST_RUN);
   assign chk_bad     = chk_hit && (chk_dout != exp_word);
   assign chk_inc     = chk_count + ONE;
   assign chk_last    = (chk_len_q != '0) && (chk_inc == chk_len_q);
   assign chk_done    = (chk_state == ST_DONE);

   always_ff @(posedge sys_clk) begin
      if (!rstn || cfg_clear) begin
         chk_state     <= ST_IDLE;
         chk_len_q     <= '0;
         chk_issued    <= '0;
         chk_count     <= '0;
         chk_cycles    <= '0;
         err_count     <= '0;
         first_err_idx <= ALL1;
         cyc_run       <= 1'b0;
      end else begin
         if (chk_rd_en) chk_issued <= chk_issued + ONE;
         if (chk_hit || cyc_run) chk_cycles <= chk_cycles + ONE;
         if (chk_hit) begin
            chk_count <= chk_inc;
            cyc_run   <= !chk_last;
         end
         if (chk_bad) begin
            if (err_count != ALL1) err_count <= err_count + ONE;
            if (first_err_idx == ALL1) first_err_idx <= chk_count;
         end
         case (chk_state)
            ST_IDLE: if (cfg_chk_en) begin
               chk_state <= ST_RUN;
               chk_len_q <= cfg_len;
            end
            ST_RUN:  if (chk_hit && chk_last) chk_state <= ST_DONE;
            ST_DONE: if (!cfg_chk_en) chk_state <= ST_IDLE;
            default: chk_state <= ST_IDLE;
         endcase
      end
   end

   btpipe_pattern_gen #(.DATA_W(DATA_W), .LFSR_SEED(LFSR_SEED)) u_chk_pat (
      .sys_clk(sys_clk), .rstn(rstn), .clear(cfg_clear), .load_mode(chk_load),
      .mode(cfg_mode), .advance(chk_hit), .word(exp_word)
   );
endmodule

// File: tb/tb_btpipe_traffic_engine.sv
// Bench for btpipe_traffic_engine: generator scoreboard, FIFO-model-fed checker, clear/reset corners.
module tb_btpipe_traffic_engine;
   logic         sys_clk = 1'b0;
   logic         rstn, cfg_clear, cfg_gen_en, cfg_chk_en, gen_full, chk_valid, chk_empty;
   logic [1:0]   cfg_mode;
   logic [31:0]  cfg_len;
   logic         gen_wr_en, chk_rd_en, gen_done, chk_done;
   logic [127:0] gen_din, chk_dout;
   logic [31:0]  gen_count, gen_cycles, chk_count, chk_cycles, err_count, first_err_idx;

   // narrow-counter instance for the saturation corner
   logic [3:0]   cfg_len4;
   logic         chk_valid4, chk_empty4, gen_wr_en4, chk_rd_en4, gen_done4, chk_done4;
   logic [127:0] chk_dout4, gen_din4;
   logic [3:0]   gen_count4, gen_cycles4, chk_count4, chk_cycles4, err_count4, first_err4;

   int n_cmp = 0, n_bad = 0, n_reads = 0, n_writes = 0;
   logic         rd;
   logic [127:0] rd_word, held, w;
   logic [127:0] gen_q[$];
   logic [127:0] p2f_q[$];

   typedef struct { logic [1:0] mode; int len; int exp_cycles; } gen_vec_t;
   gen_vec_t tbl[4];

   always #5 sys_clk = ~sys_clk;

   btpipe_traffic_engine #(.DATA_W(128), .CNT_W(32), .LFSR_SEED(32'h1)) dut (
      .sys_clk(sys_clk), .rstn(rstn), .cfg_clear(cfg_clear), .cfg_mode(cfg_mode),
      .cfg_len(cfg_len), .cfg_gen_en(cfg_gen_en), .cfg_chk_en(cfg_chk_en),
      .gen_wr_en(gen_wr_en), .gen_din(gen_din), .gen_full(gen_full),
      .chk_rd_en(chk_rd_en), .chk_dout(chk_dout), .chk_valid(chk_valid), .chk_empty(chk_empty),
      .gen_count(gen_count), .gen_cycles(gen_cycles), .gen_done(gen_done),
      .chk_count(chk_count), .chk_cycles(chk_cycles), .err_count(err_count),
      .first_err_idx(first_err_idx), .chk_done(chk_done));

   btpipe_traffic_engine #(.DATA_W(128), .CNT_W(4), .LFSR_SEED(32'h1)) dut4 (
      .sys_clk(sys_clk), .rstn(rstn), .cfg_clear(cfg_clear), .cfg_mode(cfg_mode),
      .cfg_len(cfg_len4), .cfg_gen_en(cfg_gen_en), .cfg_chk_en(cfg_chk_en),
      .gen_wr_en(gen_wr_en4), .gen_din(gen_din4), .gen_full(gen_full),
      .chk_rd_en(chk_rd_en4), .chk_dout(chk_dout4), .chk_valid(chk_valid4), .chk_empty(chk_empty4),
      .gen_count(gen_count4), .gen_cycles(gen_cycles4), .gen_done(gen_done4),
      .chk_count(chk_count4), .chk_cycles(chk_cycles4), .err_count(err_count4),
      .first_err_idx(first_err4), .chk_done(chk_done4));

   function automatic logic [31:0] step(input logic [31:0] s);
      step = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
   endfunction

   // expected word n for a mode, computed from scratch
   function automatic logic [127:0] mw(input logic [1:0] m, input int n);
      logic [31:0]  s;
      logic [127:0] r;
      s = 32'h1;
      r = '0;
      if (m == 2'd1) for (int k = 0; k < n * 4; k++) s = step(s);
      for (int i = 0; i < 4; i++) begin
         if (m == 2'd1) begin
            r[i*32 +: 32] = s;
            s = step(s);
         end else if (m == 2'd2) r[i*32 +: 32] = (n % 2 == 1) ? 32'h5555_5555 : 32'hAAAA_AAAA;
         else r[i*32 +: 32] = 32'(n * 4 + i);
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   // one clock: sample/monitor at negedge, update FIFO-model outputs after posedge
   task automatic cyc();
      @(negedge sys_clk);
      rd = chk_rd_en;
      rd_word = '0;
      if (rd) begin
         n_reads++;
         if (p2f_q.size() > 0) rd_word = p2f_q.pop_front();
      end
      if (gen_wr_en) begin
         n_writes++;
         if (gen_q.size() == 0) chk("gen_unexpected_write", 1, 0);
         else begin
            w = gen_q.pop_front();
            chk("gen_din", gen_din, w);
         end
      end
      @(posedge sys_clk);
      #1;
      chk_valid = rd;
      chk_dout  = rd_word;
      chk_empty = (p2f_q.size() == 0);
   endtask

   task automatic do_clear();
      cfg_clear = 1'b1;
      cyc();
      cfg_clear = 1'b0;
   endtask

   initial begin
      tbl[0] = '{2'd0, 4, 4};
      tbl[1] = '{2'd1, 5, 5};
      tbl[2] = '{2'd2, 6, 6};
      tbl[3] = '{2'd3, 3, 3};
      rstn = 1'b0; cfg_clear = 1'b0; cfg_gen_en = 1'b0; cfg_chk_en = 1'b0; gen_full = 1'b0;
      chk_valid = 1'b0; chk_empty = 1'b1; chk_dout = '0; cfg_mode = 2'd0; cfg_len = '0;
      cfg_len4 = '0; chk_valid4 = 1'b0; chk_empty4 = 1'b1; chk_dout4 = '0;
      repeat (3) cyc();
      rstn = 1'b1;
      cyc();

      chk("rst_gen_count", gen_count, 0);
      chk("rst_chk_count", chk_count, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_first_err", first_err_idx, 32'hFFFF_FFFF);
      chk("rst_done", {gen_done, chk_done, gen_wr_en, chk_rd_en}, 0);

      // table-driven bounded generator runs
      for (int t = 0; t < 4; t++) begin
         do_clear();
         cfg_mode = tbl[t].mode;
         cfg_len  = 32'(tbl[t].len);
         for (int n = 0; n < tbl[t].len; n++) gen_q.push_back(mw(tbl[t].mode, n));
         n_writes = 0;
         cfg_gen_en = 1'b1;
         for (int k = 0; k < 100 && !gen_done; k++) cyc();
         chk("tbl_gen_done", gen_done, 1);
         chk("tbl_gen_count", gen_count, 32'(tbl[t].len));
         chk("tbl_gen_cycles", gen_cycles, 32'(tbl[t].exp_cycles));
         repeat (2) cyc();
         chk("tbl_writes", 32'(n_writes), 32'(tbl[t].len));
         chk("tbl_queue_left", 32'(gen_q.size()), 0);
         cfg_gen_en = 1'b0;
         cyc();
      end

      // gen_full held 3 cycles mid-run
      do_clear();
      cfg_mode = 2'd0; cfg_len = 32'd4;
      for (int n = 0; n < 4; n++) gen_q.push_back(mw(2'd0, n));
      n_writes = 0;
      cfg_gen_en = 1'b1;
      cyc();
      cyc();
      gen_full = 1'b1;
      repeat (3) cyc();
      chk("full_no_write", 32'(n_writes), 1);
      gen_full = 1'b0;
      for (int k = 0; k < 100 && !gen_done; k++) cyc();
      chk("full_gen_done", gen_done, 1);
      chk("full_gen_count", gen_count, 4);
      chk("full_gen_cycles", gen_cycles, 7);
      chk("full_queue_left", 32'(gen_q.size()), 0);
      cfg_gen_en = 1'b0;
      cyc();

      // checker: LFSR stream of 256 with two corrupted words, plus surplus words
      do_clear();
      for (int n = 0; n < 260; n++) begin
         w = mw(2'd1, n);
         if (n == 17) w[5] = ~w[5];
         if (n == 200) w[100] = ~w[100];
         p2f_q.push_back(w);
      end
      chk_empty = 1'b0;
      cfg_mode = 2'd1; cfg_len = 32'd256;
      n_reads = 0;
      cfg_chk_en = 1'b1;
      for (int k = 0; k < 3000 && !chk_done; k++) cyc();
      repeat (5) cyc();
      chk("lfsr_chk_done", chk_done, 1);
      chk("lfsr_chk_count", chk_count, 256);
      chk("lfsr_err_count", err_count, 2);
      chk("lfsr_first_err", first_err_idx, 17);
      chk("lfsr_chk_cycles", chk_cycles, 256);
      chk("lfsr_reads", 32'(n_reads), 256);
      cfg_chk_en = 1'b0;
      do_clear();
      p2f_q.delete();
      chk_empty = 1'b1;

      // alternating, unbounded, pause and resume
      cfg_mode = 2'd2; cfg_len = '0;
      for (int n = 0; n < 1100; n++) gen_q.push_back(mw(2'd2, n));
      n_writes = 0;
      cfg_gen_en = 1'b1;
      repeat (1000) cyc();
      cfg_gen_en = 1'b0;
      held = gen_din;
      chk("alt_pause_word", gen_din, mw(2'd2, n_writes));
      repeat (5) cyc();
      chk("alt_pause_writes", 32'(n_writes), 999);
      chk("alt_pause_hold", gen_din, held);
      cfg_gen_en = 1'b1;
      repeat (20) cyc();
      chk("alt_gen_count", gen_count, 32'(n_writes));
      chk("alt_gen_cycles", gen_cycles, 1024);
      cfg_gen_en = 1'b0;
      do_clear();
      gen_q.delete();

      // clear with both FSMs running
      cfg_mode = 2'd0; cfg_len = '0;
      for (int n = 0; n < 100; n++) gen_q.push_back(mw(2'd0, n));
      for (int n = 0; n < 50; n++) p2f_q.push_back('0);
      chk_empty = 1'b0;
      cfg_gen_en = 1'b1; cfg_chk_en = 1'b1;
      repeat (10) cyc();
      chk("pre_clear_err", {127'd0, err_count != 0}, 1);
      cfg_clear = 1'b1; cfg_gen_en = 1'b0; cfg_chk_en = 1'b0;
      cyc();
      cfg_clear = 1'b0;
      chk("clr_counts", {gen_count, gen_cycles, chk_count, chk_cycles}, 0);
      chk("clr_err", err_count, 0);
      chk("clr_first_err", first_err_idx, 32'hFFFF_FFFF);
      chk("clr_flags", {gen_done, chk_done, gen_wr_en, chk_rd_en}, 0);
      gen_q.delete();
      p2f_q.delete();
      chk_empty = 1'b1;
      cfg_len = 32'd2;
      gen_q.push_back(mw(2'd0, 0));
      gen_q.push_back(mw(2'd0, 1));
      cfg_gen_en = 1'b1;
      for (int k = 0; k < 100 && !gen_done; k++) cyc();
      chk("restart_done", gen_done, 1);
      chk("restart_count", gen_count, 2);
      chk("restart_queue_left", 32'(gen_q.size()), 0);
      cfg_gen_en = 1'b0;
      do_clear();

      // saturating err_count on the 4-bit instance, then a 1-cycle reset
      cfg_mode = 2'd2;
      cfg_chk_en = 1'b1;
      cyc();
      chk_valid4 = 1'b1;
      repeat (20) cyc();
      chk_valid4 = 1'b0;
      cyc();
      chk("sat_err_count", err_count4, 4'd15);
      chk("sat_chk_count", chk_count4, 4'd4);
      chk("sat_first_err", first_err4, 4'd0);
      rstn = 1'b0;
      cyc();
      rstn = 1'b1;
      chk("sat_err_after_rst", err_count4, 4'd0);
      chk("sat_first_after_rst", first_err4, 4'hF);
      cfg_chk_en = 1'b0;
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
